// File: rtl/sram_word_controller.sv
// Two-phase 32-bit over 16-bit SRAM access sequencer.
// Holds ready low while the half-word phases run.
module sram_word_controller #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int PW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [PW-1:0]      r_phase;
  logic               r_is_wr;
  logic [SRAM_AW-2:0] r_word;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               w_req;
  logic               w_last;
  logic               w_active;
  logic [SRAM_AW-2:0] w_word;

  // A request seen while reset is asserted never starts an access.
  assign w_req    = (wr_en | rd_en) & rst;
  assign w_last   = (r_phase == PHASE_LAST);
  assign w_active = (r_state == S_LO) || (r_state == S_HI);
  assign w_word   =
    (SRAM_AW-1)'((address - 32'(ADDR_BASE)) >> 2);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_req) w_next = S_LO;
      S_LO:   if (w_last) w_next = S_HI;
      S_HI:   if (w_last) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Phase counter restarts at zero on entry to LO and to HI.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_phase <= '0;
    end else if (!w_active || w_last) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_is_wr <= 1'b0;
      r_word  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && w_req) begin
      r_is_wr <= wr_en;
      r_word  <= w_word;
      r_wdata <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (w_active && !r_is_wr && w_last) begin
      if (r_state == S_LO) begin
        r_rdata[15:0] <= sram_dq_in;
      end else begin
        r_rdata[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    ready       = 1'b1;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        ready = ~w_req;
      end
      S_LO, S_HI: begin
        ready     = 1'b0;
        sram_addr = {r_word, r_state == S_HI};
        sram_ce_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        if (r_is_wr) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = (r_state == S_HI) ?
                        r_wdata[31:16] : r_wdata[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      S_DONE: begin
        ready = 1'b1;
      end
      default: begin
        ready = 1'b1;
      end
    endcase
  end

  assign read_data = r_rdata;

endmodule

// File: tb/tb_sram_word_controller.sv
// Randomized and directed bench for sram_word_controller.
// Word-level reference model against a half-word SRAM model.
module tb_sram_word_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_ce_n, sram_we_n;
  logic        sram_oe_n, sram_ub_n, sram_lb_n;

  logic        z_wr, z_rd;
  logic [31:0] z_address, z_wdata, z_rdata;
  logic        z_ready;
  logic [17:0] z_sram_addr;
  logic [15:0] z_dq_out, z_dq_in;
  logic        z_dq_oe, z_ce_n, z_we_n;
  logic        z_oe_n, z_ub_n, z_lb_n;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:262143];
  logic [17:0] prev_addr;
  logic        prev_rd;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  sram_word_controller #(
    .WAIT_CYCLES(1), .ADDR_BASE(1024), .SRAM_AW(18)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_ub_n(sram_ub_n),
    .sram_lb_n(sram_lb_n)
  );

  sram_word_controller #(
    .WAIT_CYCLES(0), .ADDR_BASE(1024), .SRAM_AW(18)
  ) dut_z (
    .clk(clk), .rst(rst),
    .wr_en(z_wr), .rd_en(z_rd),
    .address(z_address), .write_data(z_wdata),
    .read_data(z_rdata), .ready(z_ready),
    .sram_addr(z_sram_addr), .sram_dq_out(z_dq_out),
    .sram_dq_in(z_dq_in), .sram_dq_oe(z_dq_oe),
    .sram_ce_n(z_ce_n), .sram_we_n(z_we_n),
    .sram_oe_n(z_oe_n), .sram_ub_n(z_ub_n),
    .sram_lb_n(z_lb_n)
  );

  // SRAM model: read data is valid only after one cycle of access time.
  always @(posedge clk) begin
    prev_addr <= sram_addr;
    prev_rd   <= !sram_ce_n && !sram_oe_n;
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq_out;
  end

  assign sram_dq_in =
    (prev_rd && !sram_ce_n && !sram_oe_n &&
     prev_addr == sram_addr) ? mem[sram_addr] : 16'h0BAD;

  assign z_dq_in = z_sram_addr[15:0] ^ 16'hC3C3;

  function automatic logic [15:0] pat(int a);
    logic [31:0] v;
    v = a;
    return v[15:0] ^ 16'h5A5A;
  endfunction

  function automatic int word_of(logic [31:0] a);
    return int'(((a - 32'd1024) >> 2) & 32'h1FFFF);
  endfunction

  function automatic logic [31:0] ref_word(int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {pat(2 * w + 1), pat(2 * w)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rd_en = 1'b1;
    address = 32'd1032;
    repeat (3) begin
      cyc();
      smp();
      checks++;
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL rst_ready got=%b exp=1", ready);
      end
      checks++;
      if (read_data !== 32'h0) begin
        failures++;
        $display("FAIL rst_rdata got=%h exp=0", read_data);
      end
      checks++;
      if ({sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n,
           sram_lb_n, sram_dq_oe} !== 6'b111110) begin
        failures++;
        $display("FAIL rst_strobes got=%b exp=111110",
          {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n,
           sram_lb_n, sram_dq_oe});
      end
    end
    cyc();
    rst = 1'b1;
    rd_en = 1'b0;
    last_rd = 32'h0;
  endtask

  task automatic test_write();
    cyc();
    wr_en = 1'b1;
    address = 32'd1032;
    write_data = 32'hDEADBEEF;
    smp();
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL wr_ready c0 got=%b exp=0", ready);
    end
    for (int c = 1; c <= 5; c++) begin
      cyc();
      smp();
      checks++;
      if (ready !== (c == 5)) begin
        failures++;
        $display("FAIL wr_ready c%0d got=%b exp=%b",
          c, ready, c == 5);
      end
      if (c <= 4) begin
        checks++;
        if (sram_addr !== ((c <= 2) ? 18'd4 : 18'd5) ||
            sram_dq_out !==
              ((c <= 2) ? 16'hBEEF : 16'hDEAD) ||
            sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
          failures++;
          $display("FAIL wr_phase c%0d addr=%0d dq=%h we_n=%b oe=%b",
            c, sram_addr, sram_dq_out, sram_we_n, sram_dq_oe);
        end
      end
    end
    ref_mem[2] = 32'hDEADBEEF;
    cyc();
    wr_en = 1'b0;
    smp();
    checks++;
    if (ready !== 1'b1 || sram_ce_n !== 1'b1) begin
      failures++;
      $display("FAIL wr_no_retrigger ready=%b ce_n=%b exp=1,1",
        ready, sram_ce_n);
    end
  endtask

  task automatic test_readback();
    cyc();
    rd_en = 1'b1;
    address = 32'd1032;
    smp();
    for (int c = 1; c <= 5; c++) begin
      cyc();
      smp();
      if (c <= 4) begin
        checks++;
        if (sram_oe_n !== 1'b0 || sram_dq_oe !== 1'b0 ||
            sram_we_n !== 1'b1) begin
          failures++;
          $display("FAIL rd_strobes c%0d oe_n=%b dq_oe=%b we_n=%b",
            c, sram_oe_n, sram_dq_oe, sram_we_n);
        end
      end
    end
    last_rd = ref_word(2);
    checks++;
    if (ready !== 1'b1 || read_data !== last_rd) begin
      failures++;
      $display("FAIL rd_data ready=%b got=%h exp=%h",
        ready, read_data, last_rd);
    end
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic test_simultaneous();
    cyc();
    wr_en = 1'b1;
    rd_en = 1'b1;
    address = 32'd1024;
    write_data = 32'h12345678;
    smp();
    for (int c = 1; c <= 5; c++) begin
      cyc();
      smp();
      if (c == 1 || c == 3) begin
        checks++;
        if (sram_we_n !== 1'b0 ||
            sram_addr !== ((c == 1) ? 18'd0 : 18'd1) ||
            sram_dq_out !==
              ((c == 1) ? 16'h5678 : 16'h1234)) begin
          failures++;
          $display("FAIL both_wr c%0d we_n=%b addr=%0d dq=%h",
            c, sram_we_n, sram_addr, sram_dq_out);
        end
      end
    end
    ref_mem[0] = 32'h12345678;
    checks++;
    if (read_data !== last_rd) begin
      failures++;
      $display("FAIL both_rdata got=%h exp=%h",
        read_data, last_rd);
    end
    cyc();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_mid_access();
    cyc();
    rd_en = 1'b1;
    address = 32'd1024 + 32'd4 * 37;
    smp();
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 2) begin
        rd_en = 1'b0;
        address = 32'd1024 + 32'd4 * 99;
      end
      smp();
      if (c <= 4) begin
        checks++;
        if (sram_addr !== ((c <= 2) ? 18'd74 : 18'd75)) begin
          failures++;
          $display("FAIL mid_addr c%0d got=%0d exp=%0d",
            c, sram_addr, (c <= 2) ? 74 : 75);
        end
      end
    end
    last_rd = ref_word(37);
    checks++;
    if (ready !== 1'b1 || read_data !== last_rd) begin
      failures++;
      $display("FAIL mid_done ready=%b got=%h exp=%h",
        ready, read_data, last_rd);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    d = $urandom;
    cyc();
    wr_en = 1'b1;
    address = 32'd1024 + 32'd4 * 5000;
    write_data = d;
    smp();
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    wr_en = 1'b0;
    smp();
    checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== 18'd10001) begin
      failures++;
      $display("FAIL abort_c3 we_n=%b addr=%0d exp=0,10001",
        sram_we_n, sram_addr);
    end
    cyc();
    rst = 1'b1;
    smp();
    ref_mem[5000] = d;
    last_rd = 32'h0;
    checks++;
    if (ready !== 1'b1 ||
        {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n,
         sram_lb_n, sram_dq_oe} !== 6'b111110 ||
        read_data !== 32'h0) begin
      failures++;
      $display("FAIL abort_idle ready=%b strobes=%b rdata=%h",
        ready, {sram_ce_n, sram_we_n, sram_oe_n, sram_ub_n,
                sram_lb_n, sram_dq_oe}, read_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      logic        is_wr;
      logic [31:0] a, d;
      int          w;
      int          op;
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0)
        a = 32'd1024 + 32'd4 * $urandom_range(0, 31)
            + $urandom_range(0, 3);
      else
        a = $urandom;
      d = $urandom;
      w = word_of(a);
      is_wr = (op == 0 || op == 3);
      cyc();
      wr_en = is_wr;
      rd_en = (op != 0);
      address = a;
      write_data = d;
      smp();
      checks++;
      if (ready !== 1'b0) begin
        failures++;
        $display("FAIL rnd_ready n%0d c0 got=%b exp=0", n, ready);
      end
      for (int c = 1; c <= 5; c++) begin
        cyc();
        if ($urandom_range(0, 1) == 1) begin
          address = $urandom;
          write_data = $urandom;
        end
        smp();
        if (c <= 4) begin
          logic [17:0] ea;
          ea = 18'(2 * w + ((c >= 3) ? 1 : 0));
          checks++;
          if (ready !== 1'b0 || sram_addr !== ea ||
              sram_ce_n !== 1'b0 || sram_we_n !== !is_wr ||
              sram_oe_n !== is_wr || sram_dq_oe !== is_wr) begin
            failures++;
            $display("FAIL rnd_phase n%0d c%0d addr=%0d exp=%0d we_n=%b oe_n=%b",
              n, c, sram_addr, ea, sram_we_n, sram_oe_n);
          end
          if (is_wr) begin
            checks++;
            if (sram_dq_out !== ((c >= 3) ? d[31:16] : d[15:0])) begin
              failures++;
              $display("FAIL rnd_dq n%0d c%0d got=%h exp=%h",
                n, c, sram_dq_out,
                (c >= 3) ? d[31:16] : d[15:0]);
            end
          end
        end
      end
      if (is_wr) ref_mem[w] = d;
      else last_rd = ref_word(w);
      checks++;
      if (ready !== 1'b1 || read_data !== last_rd) begin
        failures++;
        $display("FAIL rnd_done n%0d ready=%b got=%h exp=%h",
          n, ready, read_data, last_rd);
      end
      if ($urandom_range(0, 1) == 1) begin
        cyc();
        wr_en = 1'b0;
        rd_en = 1'b0;
        smp();
        checks++;
        if (ready !== 1'b1 || sram_ce_n !== 1'b1) begin
          failures++;
          $display("FAIL rnd_gap n%0d ready=%b ce_n=%b",
            n, ready, sram_ce_n);
        end
      end
    end
    cyc();
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_wait0();
    logic [31:0] exp;
    exp = {16'd7 ^ 16'hC3C3, 16'd6 ^ 16'hC3C3};
    cyc();
    z_rd = 1'b1;
    z_address = 32'd1024 + 32'd12;
    smp();
    for (int c = 0; c <= 3; c++) begin
      if (c > 0) begin
        cyc();
        smp();
      end
      checks++;
      if (z_ready !== (c == 3)) begin
        failures++;
        $display("FAIL w0_ready c%0d got=%b exp=%b",
          c, z_ready, c == 3);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if (z_sram_addr !== ((c == 1) ? 18'd6 : 18'd7)) begin
          failures++;
          $display("FAIL w0_addr c%0d got=%0d", c, z_sram_addr);
        end
      end
    end
    checks++;
    if (z_rdata !== exp) begin
      failures++;
      $display("FAIL w0_rdata got=%h exp=%h", z_rdata, exp);
    end
    cyc();
    z_rd = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = pat(i);
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    address = '0;
    write_data = '0;
    z_wr = 1'b0;
    z_rd = 1'b0;
    z_address = '0;
    z_wdata = '0;
    last_rd = '0;
    test_reset();
    test_write();
    test_readback();
    test_simultaneous();
    test_mid_access();
    test_reset_abort();
    test_back_to_back();
    test_wait0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
